// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the AES round sequencer.
//   state_t       : controller state encoding (bus-facing and round-loop states)
//   STG_*         : bit positions of the per-stage enable/done vectors
//   ROUND_W       : width of the round index
//   stage_onehot  : decodes a state into its stage enable vector
package aes_ctrl_pkg;

  localparam int ROUND_W    = 4;
  localparam int NUM_STG    = 5;
  localparam int STG_KEYEXP = 0;
  localparam int STG_SBYTES = 1;
  localparam int STG_SROWS  = 2;
  localparam int STG_MCOL   = 3;
  localparam int STG_AROUND = 4;

  typedef enum logic [4:0] {
    S_IDLE_KEY,
    S_KEY_ADDR,
    S_KEY_WAIT,
    S_KEY_LOAD,
    S_IDLE,
    S_ADDR,
    S_SEND,
    S_WAIT,
    S_LOAD,
    S_INIT_ARK,
    S_KEYEXP,
    S_SBYTES,
    S_SROWS,
    S_MCOL,
    S_AROUND,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  // The initial AddRoundKey reuses the AddRoundKey unit, hence the shared bit.
  function automatic logic [NUM_STG-1:0] stage_onehot(input state_t s);
    logic [NUM_STG-1:0] v;
    v = '0;
    case (s)
      S_INIT_ARK, S_AROUND: v[STG_AROUND] = 1'b1;
      S_KEYEXP:             v[STG_KEYEXP] = 1'b1;
      S_SBYTES:             v[STG_SBYTES] = 1'b1;
      S_SROWS:              v[STG_SROWS]  = 1'b1;
      S_MCOL:               v[STG_MCOL]   = 1'b1;
      default:              v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// AHB-lite style slave handshake bundle for the AES round sequencer.
//   hsel, addr_match, m_write, m_read, key_sel, data_ready : master -> slave
//   hresp, hreadyout                                        : slave -> master
interface aes_round_sequencer_if;
  logic hsel;
  logic addr_match;
  logic m_write;
  logic m_read;
  logic key_sel;
  logic data_ready;
  logic hresp;
  logic hreadyout;

  modport master (
    output hsel, addr_match, m_write, m_read, key_sel, data_ready,
    input  hresp, hreadyout
  );

  modport slave (
    input  hsel, addr_match, m_write, m_read, key_sel, data_ready,
    output hresp, hreadyout
  );
endinterface

// File: rtl/aes_round_sequencer_stage_timer.sv
// Stage watchdog: counts cycles spent in the current round-loop stage.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clear    : restart the count (asserted on every state change)
//   i_en       : count this cycle (a stage is active)
//   o_expired  : this is the STAGE_TIMEOUT-th cycle of the stage without a move
// STAGE_TIMEOUT = 0 disables expiry.
module aes_stage_timer #(
  parameter int STAGE_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = (STAGE_TIMEOUT < 2) ? 1 : $clog2(STAGE_TIMEOUT + 1);
  // Count is 0 in the first stage cycle, so the last allowed cycle sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((STAGE_TIMEOUT > 0) ? STAGE_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en)    r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_expired = (STAGE_TIMEOUT != 0) && i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round controller: bus-facing slave FSM plus the per-round stage loop.
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : hsel/addr_match/m_write/m_read/key_sel/data_ready in,
//                    hresp/hreadyout out
//   i_stage_done   : one-cycle done per stage {around,mcol,srows,sbytes,keyexp}
//   o_stage_en     : level enable per stage, same order, at most one set
//   o_round_idx    : current round, feeds the key schedule
//   o_final_round  : last round of the operation (no MixColumns)
//   o_key_loaded   : a valid key is held
//   o_busy         : round loop active
//   i_decrypt      : only with AES_DECRYPT_EN; selects inverse sequencing, sampled in LOAD
// Build option: define AES_DECRYPT_EN to add decrypt sequencing.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS    = 10,
  parameter int STAGE_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  aes_round_sequencer_if.slave bus,
`ifdef AES_DECRYPT_EN
  input  logic                i_decrypt,
`endif
  input  logic [NUM_STG-1:0]  i_stage_done,
  output logic [NUM_STG-1:0]  o_stage_en,
  output logic [ROUND_W-1:0]  o_round_idx,
  output logic                o_final_round,
  output logic                o_key_loaded,
  output logic                o_busy
);

  localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS);

  state_t             r_state;
  state_t             w_next;
  logic [ROUND_W-1:0] r_round_idx;
  logic               r_key_loaded;
  logic               w_final;
  logic               w_busy;
  logic               w_adv;
  logic               w_expired;
  logic               w_dec;
  logic               w_dec_load;
  logic [NUM_STG-1:0] w_stage_en;

`ifdef AES_DECRYPT_EN
  logic r_decrypt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_decrypt <= 1'b0;
    else if (r_state == S_LOAD) r_decrypt <= i_decrypt;
  end

  assign w_dec      = r_decrypt;
  // The LOAD -> INIT_ARK edge needs the direction before r_decrypt updates.
  assign w_dec_load = i_decrypt;
`else
  assign w_dec      = 1'b0;
  assign w_dec_load = 1'b0;
`endif

  assign w_stage_en = stage_onehot(r_state);
  assign w_busy     = r_state inside {S_INIT_ARK, S_KEYEXP, S_SBYTES, S_SROWS, S_MCOL, S_AROUND};
  // Only the done bit of the active stage can advance the loop.
  assign w_adv      = |(i_stage_done & w_stage_en);
  // Decrypt counts down, so its last round is index 0.
  assign w_final    = w_dec ? (r_round_idx == '0) : (r_round_idx == LAST);

  aes_stage_timer #(
    .STAGE_TIMEOUT(STAGE_TIMEOUT)
  ) u_stage_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_next != r_state),
    .i_en      (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE_KEY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE_KEY: if (bus.hsel) w_next = S_KEY_ADDR;
      // Without a key only a key write is useful; a data write is an error.
      S_KEY_ADDR: begin
        if (bus.addr_match && bus.m_write) w_next = bus.key_sel ? S_KEY_WAIT : S_ERR1;
        else                               w_next = S_IDLE_KEY;
      end
      S_KEY_WAIT: if (bus.data_ready) w_next = S_KEY_LOAD;
      S_KEY_LOAD: w_next = S_IDLE;
      S_IDLE:     if (bus.hsel) w_next = S_ADDR;
      S_ADDR: begin
        if (!bus.addr_match)   w_next = S_IDLE;
        else if (bus.m_read)   w_next = S_SEND;
        else if (bus.m_write) begin
          if (bus.key_sel)     w_next = S_KEY_WAIT;
          else if (r_key_loaded) w_next = S_WAIT;
          else                 w_next = S_ERR1;
        end
        else                   w_next = S_IDLE;
      end
      S_SEND:     w_next = S_IDLE;
      S_WAIT:     if (bus.data_ready) w_next = S_LOAD;
      S_LOAD:     w_next = S_INIT_ARK;
      S_INIT_ARK: if (w_adv) w_next = w_dec ? S_SROWS : S_KEYEXP;
      S_KEYEXP:   if (w_adv) w_next = S_SBYTES;
      S_SBYTES:   if (w_adv) w_next = w_dec ? S_AROUND : S_SROWS;
      S_SROWS: begin
        if (w_adv) begin
          if (w_dec)        w_next = S_SBYTES;
          else if (w_final) w_next = S_AROUND;
          else              w_next = S_MCOL;
        end
      end
      S_MCOL:     if (w_adv) w_next = w_dec ? S_SROWS : S_AROUND;
      S_AROUND: begin
        if (w_adv) begin
          if (w_final)    w_next = S_DONE;
          else if (w_dec) w_next = S_MCOL;
          else            w_next = S_KEYEXP;
        end
      end
      S_DONE:     w_next = S_IDLE;
      S_ERR1:     w_next = S_ERR2;
      S_ERR2:     w_next = S_IDLE;
      default:    w_next = S_IDLE_KEY;
    endcase
    if (w_busy && !w_adv && w_expired) w_next = S_ERR1;
  end

  // Round index changes only on entry to the states that own it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round_idx <= '0;
    end else if (w_next != r_state) begin
      if (w_next == S_INIT_ARK)               r_round_idx <= w_dec_load ? LAST : '0;
      else if (w_next == S_KEYEXP)            r_round_idx <= r_round_idx + ROUND_W'(1);
      else if (w_dec && w_next == S_SROWS)    r_round_idx <= r_round_idx - ROUND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_key_loaded <= 1'b0;
    else if (r_state == S_KEY_LOAD) r_key_loaded <= 1'b1;
  end

  assign o_stage_en    = w_stage_en;
  assign o_round_idx   = r_round_idx;
  assign o_final_round = w_final;
  assign o_key_loaded  = r_key_loaded;
  assign o_busy        = w_busy;
  assign bus.hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign bus.hreadyout = r_state inside {S_IDLE_KEY, S_KEY_ADDR, S_IDLE, S_ADDR,
                                         S_SEND, S_DONE, S_ERR2};

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer (NUM_ROUNDS=10, STAGE_TIMEOUT=255).
// Stage units respond combinationally: done follows enable unless masked.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] stage_en;
  logic [4:0] stage_done;
  logic [4:0] hold_mask;
  logic [4:0] inj;
  logic [3:0] round_idx;
  logic       final_round;
  logic       key_loaded;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_keyexp, n_mcol, n_rise, n_any_en, n_multi;
  logic [4:0] prev_en;
  logic       prev_hrdy;

  always #5 clk = ~clk;

  aes_round_sequencer_if bus();

  assign stage_done = (stage_en & ~hold_mask) | inj;

  aes_round_sequencer #(
    .NUM_ROUNDS(10),
    .STAGE_TIMEOUT(255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
`ifdef AES_DECRYPT_EN
    .i_decrypt    (1'b0),
`endif
    .i_stage_done (stage_done),
    .o_stage_en   (stage_en),
    .o_round_idx  (round_idx),
    .o_final_round(final_round),
    .o_key_loaded (key_loaded),
    .o_busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (stage_en[0] && !prev_en[0]) n_keyexp++;
    if (stage_en[3] && !prev_en[3]) n_mcol++;
    if (bus.hreadyout && !prev_hrdy) n_rise++;
    if (|stage_en) n_any_en++;
    if ($countones(stage_en) > 1) n_multi++;
    prev_en   = stage_en;
    prev_hrdy = bus.hreadyout;
  endtask

  task automatic clr_counts();
    n_keyexp = 0; n_mcol = 0; n_rise = 0; n_any_en = 0;
    prev_en   = stage_en;
    prev_hrdy = bus.hreadyout;
  endtask

  task automatic bus_idle();
    bus.hsel = 0; bus.addr_match = 0; bus.m_write = 0;
    bus.m_read = 0; bus.key_sel = 0; bus.data_ready = 0;
  endtask

  // Select then present the address phase; leaves the FSM one state past ADDR.
  task automatic access(input logic wr, input logic rd, input logic ksel);
    bus.hsel = 1;
    tick();
    bus.hsel = 0; bus.addr_match = 1; bus.m_write = wr; bus.m_read = rd; bus.key_sel = ksel;
    tick();
    bus_idle();
  endtask

  initial begin
    int t;
    int s_tick;
    logic found;
    n_multi = 0;
    bus_idle();
    hold_mask = '0;
    inj = '0;
    rst = 1;
    prev_en = '0;
    prev_hrdy = 1'b0;
    clr_counts();
    tick(); tick();

    // Reset state
    chk("rst_stage_en", stage_en, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hresp", bus.hresp, 0);
    chk("rst_hreadyout", bus.hreadyout, 1);
    rst = 0;
    tick();
    clr_counts();

    // Data write with no key: two-cycle error response
    access(1'b1, 1'b0, 1'b0);
    chk("nokey_err1_hresp", bus.hresp, 1);
    chk("nokey_err1_hready", bus.hreadyout, 0);
    tick();
    chk("nokey_err2_hresp", bus.hresp, 1);
    chk("nokey_err2_hready", bus.hreadyout, 1);
    tick();
    chk("nokey_idle_hresp", bus.hresp, 0);
    chk("nokey_idle_hready", bus.hreadyout, 1);
    chk("nokey_no_stage_en", n_any_en, 0);
    chk("nokey_key_loaded", key_loaded, 0);

    // Key write
    access(1'b1, 1'b0, 1'b1);
    chk("keywait_hready", bus.hreadyout, 0);
    bus.data_ready = 1;
    tick();
    bus.data_ready = 0;
    chk("keyload_hready", bus.hreadyout, 0);
    chk("keyload_not_yet_loaded", key_loaded, 0);
    tick();
    chk("key_loaded", key_loaded, 1);
    chk("key_idle_hready", bus.hreadyout, 1);

    // Read: SEND then IDLE
    access(1'b0, 1'b1, 1'b0);
    chk("send_hready", bus.hreadyout, 1);
    chk("send_busy", busy, 0);
    chk("send_hresp", bus.hresp, 0);
    tick();

    // Full encrypt
    access(1'b1, 1'b0, 1'b0);
    chk("wait_hready", bus.hreadyout, 0);
    clr_counts();
    bus.data_ready = 1;
    t = 0;
    do begin
      tick();
      t++;
      bus.data_ready = 0;
      if (t == 2) begin
        chk("init_ark_en", stage_en, 5'h10);
        chk("init_ark_idx", round_idx, 0);
      end
      if (t == 3) begin
        chk("r1_keyexp_en", stage_en, 5'h01);
        chk("r1_idx", round_idx, 1);
      end
      if (t == 50) chk("r10_srows_final", final_round, 1);
      if (t == 51) chk("r10_skip_mcol", stage_en, 5'h10);
    end while (!bus.hreadyout && t < 200);
    chk("enc_latency", t, 52);
    chk("enc_keyexp_count", n_keyexp, 10);
    chk("enc_mcol_count", n_mcol, 9);
    chk("done_round_idx", round_idx, 10);
    chk("done_busy", busy, 0);
    chk("done_hresp", bus.hresp, 0);
    tick();
    chk("enc_hready_rises", n_rise, 1);
    chk("idle_round_idx_held", round_idx, 10);
    chk("enc_onehot", n_multi, 0);

    // Watchdog: hold SBYTES in round 3, with wrong-stage pulses meanwhile
    access(1'b1, 1'b0, 1'b0);
    bus.data_ready = 1;
    found = 0; s_tick = 0; t = 0;
    while (t < 2000 && !bus.hresp) begin
      tick();
      t++;
      bus.data_ready = 0;
      if (!found && stage_en == 5'h02 && round_idx == 3) begin
        found = 1;
        s_tick = t;
        hold_mask = 5'h02;
      end
      inj = (found && t - s_tick < 6) ? 5'b11101 : 5'b00000;
    end
    chk("wd_found_sbytes_r3", found, 1);
    chk("wd_err1_delay", t - s_tick, 255);
    chk("wd_err1_hready", bus.hreadyout, 0);
    chk("wd_err1_stage_en", stage_en, 0);
    chk("wd_key_kept", key_loaded, 1);
    hold_mask = '0;
    inj = '0;
    tick();
    chk("wd_err2_hresp", bus.hresp, 1);
    chk("wd_err2_hready", bus.hreadyout, 1);
    tick();
    chk("wd_idle_hresp", bus.hresp, 0);

    // Reset during MCOL of round 5, with hsel asserted alongside
    access(1'b1, 1'b0, 1'b0);
    bus.data_ready = 1;
    found = 0; t = 0;
    while (t < 200 && !found) begin
      tick();
      t++;
      bus.data_ready = 0;
      if (stage_en == 5'h08 && round_idx == 5) found = 1;
    end
    chk("rst_found_mcol_r5", found, 1);
    rst = 1;
    bus.hsel = 1;
    tick();
    chk("midrst_stage_en", stage_en, 0);
    chk("midrst_round_idx", round_idx, 0);
    chk("midrst_key_loaded", key_loaded, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_hready", bus.hreadyout, 1);
    rst = 0;
    bus.hsel = 0;
    tick();
    // Key must be reloaded: a data write now errors
    access(1'b1, 1'b0, 1'b0);
    chk("rekey_needed_hresp", bus.hresp, 1);
    chk("rekey_needed_hready", bus.hreadyout, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
